// File: rtl/seq_multree.sv
// Sequential carry-save multiplier: retires R multiplier bits per cycle into a
// (sum, carry) pair, then resolves them with one carry-propagate add.
module seq_multree #(
    parameter int W = 58,
    parameter int R = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           signed_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out,
    output logic           busy
);

    localparam int ITER = (W + R - 1) / R;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int PW   = 2 * W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ADD,
        DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          sgn_q;
    logic [CW-1:0] cnt;
    logic [PW-1:0] s_q;
    logic [PW-1:0] t_q;
    logic [PW-1:0] s_nxt;
    logic [PW-1:0] t_nxt;
    logic [PW-1:0] a_ext;
    logic [W-1:0]  b_grp;

    assign a_ext = sgn_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
    // Bits shifted in from above the multiplier are zero, so a short last group needs no mask.
    assign b_grp = b_q >> (int'(cnt) * R);

    // One 3:2 compressor per partial product; each frees bit 0 of its carry
    // vector, which is where the +1 of the negated sign-row goes.
    always_comb begin : csa_tree
        logic [PW-1:0] s_acc;
        logic [PW-1:0] t_acc;
        logic [PW-1:0] pp;
        logic [PW-1:0] maj;
        logic          cin;
        int            idx;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        s_acc = s_q;
        t_acc = t_q;
        pp    = '0;
        maj   = '0;
        cin   = 1'b0;
        idx   = 0;
        for (int k = 0; k < R; k++) begin
            idx = int'(cnt) * R + k;
            pp  = b_grp[k] ? (a_ext << idx) : '0;
            cin = 1'b0;
            if (sgn_q && idx == W - 1) begin
                pp  = ~pp;
                cin = 1'b1;
            end
            maj   = (s_acc & t_acc) | (s_acc & pp) | (t_acc & pp);
            s_acc = s_acc ^ t_acc ^ pp;
            t_acc = {maj[PW-2:0], cin};
        end
        s_nxt = s_acc;
        t_nxt = t_acc;
    end

    // NOTE: state is updated with non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are reset too, so nothing from an aborted product leaks out.
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            cnt       <= '0;
            s_q       <= '0;
            t_q       <= '0;
            out       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        sgn_q    <= signed_mode;
                        s_q      <= '0;
                        t_q      <= '0;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    s_q <= s_nxt;
                    t_q <= t_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1)) begin
                        state <= ADD;
                    end
                end
                ADD: begin
                    out       <= s_q + t_q;
                    state     <= DONE;
                    busy      <= 1'b0;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    // New operands are only taken once back in IDLE.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multree.sv
// Directed bench for seq_multree: default W=58,R=2 instance plus a W=8,R=3
// instance with a partial last group.
module tb_seq_multree;

    localparam int W  = 58;
    localparam int W8 = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            signed_mode = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*W-1:0]  out;
    logic            busy;

    logic            in_valid8 = 1'b0;
    logic            in_ready8;
    logic [W8-1:0]   a8 = '0;
    logic [W8-1:0]   b8 = '0;
    logic            signed_mode8 = 1'b0;
    logic            out_valid8;
    logic            out_ready8 = 1'b0;
    logic [2*W8-1:0] out8;
    logic            busy8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_multree #(.W(W), .R(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .busy(busy)
    );

    seq_multree #(.W(W8), .R(3)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .signed_mode(signed_mode8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out(out8), .busy(busy8)
    );

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           sgn;
        logic [2*W-1:0] exp;
    } vec_t;

    typedef struct {
        logic [W8-1:0]   a;
        logic [W8-1:0]   b;
        logic            sgn;
        logic [2*W8-1:0] exp;
    } vec8_t;

    vec_t  vecs[9];
    vec8_t vecs8[6];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands for one cycle, scrambles the inputs afterwards, and
    // returns the product plus the cycle index at which out_valid first rose.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic ts,
                          output logic [2*W-1:0] prod, output int lat,
                          output logic busy1, output logic rdy1);
        a = ta; b = tb_b; signed_mode = ts; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = ~ta; b = ~tb_b; signed_mode = ~ts;
        lat = 1;
        busy1 = busy;
        rdy1 = in_ready;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        prod = out;
    endtask

    task automatic run_op8(input logic [W8-1:0] ta, input logic [W8-1:0] tb_b, input logic ts,
                           output logic [2*W8-1:0] prod, output int lat);
        a8 = ta; b8 = tb_b; signed_mode8 = ts; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0; a8 = ~ta; b8 = ~tb_b; signed_mode8 = ~ts;
        lat = 1;
        while (!out_valid8 && lat < 200) begin
            tick();
            lat++;
        end
        prod = out8;
    endtask

    task automatic release_out(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_idle_rdy"}, 128'(in_ready), 128'(1));
    endtask

    initial begin : main
        logic [W-1:0]    all58;
        logic [2*W-1:0]  prod;
        logic [2*W8-1:0] prod8;
        logic [2*W-1:0]  held;
        logic            busy1;
        logic            rdy1;
        int              lat;
        int              bad;

        all58 = {W{1'b1}};
        vecs[0] = '{a: 58'd3,         b: 58'd5,          sgn: 1'b0, exp: 116'd15};
        vecs[1] = '{a: all58,         b: all58,          sgn: 1'b0,
                    exp: 116'((128'd1 << 116) - (128'd1 << 59) + 128'd1)};
        vecs[2] = '{a: 58'd0,         b: all58,          sgn: 1'b0, exp: 116'd0};
        vecs[3] = '{a: all58,         b: 58'd1,          sgn: 1'b1, exp: {116{1'b1}}};
        vecs[4] = '{a: 58'd1 << 57,   b: 58'd1 << 57,    sgn: 1'b1, exp: 116'd1 << 114};
        vecs[5] = '{a: all58 - 58'd2, b: 58'd5,          sgn: 1'b1, exp: ~116'd14};
        vecs[6] = '{a: 58'd7,         b: all58,          sgn: 1'b1, exp: ~116'd6};
        vecs[7] = '{a: all58,         b: 58'd1,          sgn: 1'b0, exp: {58'd0, all58}};
        vecs[8] = '{a: 58'd1 << 57,   b: all58,          sgn: 1'b1, exp: 116'd1 << 57};

        vecs8[0] = '{a: 8'hFF, b: 8'hFF, sgn: 1'b0, exp: 16'd65025};
        vecs8[1] = '{a: 8'h80, b: 8'hFF, sgn: 1'b1, exp: 16'd128};
        vecs8[2] = '{a: 8'h80, b: 8'h80, sgn: 1'b1, exp: 16'd16384};
        vecs8[3] = '{a: 8'h7F, b: 8'h80, sgn: 1'b1, exp: 16'd49280};
        vecs8[4] = '{a: 8'd200, b: 8'd3, sgn: 1'b0, exp: 16'd600};
        vecs8[5] = '{a: 8'hFD, b: 8'h05, sgn: 1'b1, exp: 16'd65521};

        // Reset state, sampled while rst is still asserted.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_out", 128'(out), 128'(0));
        check("rst8_in_ready", 128'(in_ready8), 128'(1));
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, prod, lat, busy1, rdy1);
            check($sformatf("vec%0d_prod", i), 128'(prod), 128'(vecs[i].exp));
            check($sformatf("vec%0d_lat", i), 128'(lat), 128'(31));
            check($sformatf("vec%0d_busy_run", i), 128'({busy1, rdy1}), 128'(2'b10));
            check($sformatf("vec%0d_busy_done", i), 128'(busy), 128'(0));
            release_out($sformatf("vec%0d", i));
        end

        // Backpressure: result held while out_ready stays low, in_valid ignored.
        run_op(58'd100, 58'd200, 1'b0, prod, lat, busy1, rdy1);
        check("bp_prod", 128'(prod), 128'(20000));
        held = out;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 58'(i + 40);
            b = 58'(i + 90);
            tick();
            if (out !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        check("bp_stable_cycles_bad", 128'(bad), 128'(0));
        release_out("bp");
        check("bp_released_valid", 128'(out_valid), 128'(0));
        run_op(58'd11, 58'd13, 1'b0, prod, lat, busy1, rdy1);
        check("bp_second_prod", 128'(prod), 128'(143));
        check("bp_second_lat", 128'(lat), 128'(31));
        release_out("bp2");

        // Reset in cycle 10 of a RUN discards the in-flight product.
        a = all58; b = all58; signed_mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("midrst_busy_before", 128'(busy), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_out", 128'(out), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        run_op(58'd7, 58'd9, 1'b0, prod, lat, busy1, rdy1);
        check("midrst_prod", 128'(prod), 128'(63));
        check("midrst_lat", 128'(lat), 128'(31));
        release_out("midrst");

        // W=8, R=3: three RUN cycles, last group holds only two real bits.
        for (int i = 0; i < 6; i++) begin
            run_op8(vecs8[i].a, vecs8[i].b, vecs8[i].sgn, prod8, lat);
            check($sformatf("w8_vec%0d_prod", i), 128'(prod8), 128'(vecs8[i].exp));
            check($sformatf("w8_vec%0d_lat", i), 128'(lat), 128'(5));
            out_ready8 = 1'b1;
            tick();
            out_ready8 = 1'b0;
            check($sformatf("w8_vec%0d_idle", i), 128'(in_ready8), 128'(1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
